// File: rtl/fsm_rtc_seq.sv
// rtl/fsm_rtc_seq.sv - RTC access sequencer: init/write/read bursts, auto-read refresh, sw write requests
// Optional listo watchdog built when FSM_SEQ_TIMEOUT_EN is defined.
module fsm_rtc_seq #(
  parameter int unsigned POS_W       = 2,
  parameter int unsigned N_POS       = 4,
  parameter int unsigned N_INIT      = 2,
  parameter int unsigned REFRESH_CYC = 290,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             listo,
  input  logic             sw,
  output logic [POS_W-1:0] posicion,
  output logic             enable_inicio,
  output logic             enable_escribir,
  output logic             enable_leer,
  output logic [2:0]       estado,
  output logic             ocupado,
  output logic             error
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3
  } state_t;

  localparam logic [CNT_W-1:0] REF_LAST   = CNT_W'(REFRESH_CYC - 1);
  localparam logic [POS_W-1:0] INIT_LAST  = POS_W'(N_INIT - 1);
  localparam logic [POS_W-1:0] BURST_LAST = POS_W'(N_POS - 1);

  state_t           state, state_nxt;
  logic [POS_W-1:0] pos_nxt;
  logic [POS_W-1:0] last_pos;
  logic             sw_q, sw_rise;
  logic             pend, pend_nxt;
  logic [CNT_W-1:0] ref_cnt, ref_nxt;

`ifdef FSM_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] wd_cnt, wd_nxt;
  logic             err_nxt;
`endif

  always_comb begin
    state_nxt = state;
    pos_nxt   = posicion;
    pend_nxt  = pend;
    ref_nxt   = '0;
    sw_rise   = sw & ~sw_q;
    last_pos  = (state == ST_INIT) ? INIT_LAST : BURST_LAST;
`ifdef FSM_SEQ_TIMEOUT_EN
    wd_nxt    = '0;
    err_nxt   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        // A write request always beats a due refresh.
        if (sw_rise || pend) begin
          state_nxt = ST_WRITE;
          pos_nxt   = '0;
          pend_nxt  = 1'b0;
        end else if (ref_cnt == REF_LAST) begin
          state_nxt = ST_READ;
          pos_nxt   = '0;
        end else begin
          ref_nxt = ref_cnt + 1'b1;
        end
      end
      default: begin
        if (sw_rise) pend_nxt = 1'b1;
        if (listo) begin
          if (posicion == last_pos) begin
            state_nxt = ST_IDLE;
            pos_nxt   = '0;
          end else begin
            pos_nxt = posicion + 1'b1;
          end
        end
`ifdef FSM_SEQ_TIMEOUT_EN
        else if (wd_cnt == WD_LAST) begin
          // A stuck init is retried; a stuck data burst is abandoned.
          err_nxt   = 1'b1;
          pos_nxt   = '0;
          state_nxt = (state == ST_INIT) ? ST_INIT : ST_IDLE;
        end else begin
          wd_nxt = wd_cnt + 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_INIT;
      posicion        <= '0;
      enable_inicio   <= 1'b1;
      enable_escribir <= 1'b0;
      enable_leer     <= 1'b0;
      ocupado         <= 1'b1;
      sw_q            <= 1'b0;
      pend            <= 1'b0;
      ref_cnt         <= '0;
`ifdef FSM_SEQ_TIMEOUT_EN
      wd_cnt          <= '0;
      error           <= 1'b0;
`endif
    end else begin
      state           <= state_nxt;
      posicion        <= pos_nxt;
      enable_inicio   <= (state_nxt == ST_INIT);
      enable_escribir <= (state_nxt == ST_WRITE);
      enable_leer     <= (state_nxt == ST_READ);
      ocupado         <= (state_nxt != ST_IDLE);
      sw_q            <= sw;
      pend            <= pend_nxt;
      ref_cnt         <= ref_nxt;
`ifdef FSM_SEQ_TIMEOUT_EN
      wd_cnt          <= wd_nxt;
      error           <= err_nxt;
`endif
    end
  end

`ifndef FSM_SEQ_TIMEOUT_EN
  assign error = 1'b0;
`endif

  assign estado = state;

endmodule

// File: tb/tb_fsm_rtc_seq.sv
// tb/tb_fsm_rtc_seq.sv - self-checking bench for fsm_rtc_seq
// Directed scenarios followed by randomized listo/sw/reset against a behavioural model.
module tb_fsm_rtc_seq;

  localparam int POS_W       = 2;
  localparam int N_POS       = 4;
  localparam int N_INIT      = 2;
  localparam int REFRESH_CYC = 8;
  localparam int TIMEOUT_CYC = 16;
  localparam int CNT_W       = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             listo;
  logic             sw;
  logic [POS_W-1:0] posicion;
  logic             enable_inicio, enable_escribir, enable_leer;
  logic [2:0]       estado;
  logic             ocupado;
  logic             error;

  fsm_rtc_seq #(
    .POS_W(POS_W), .N_POS(N_POS), .N_INIT(N_INIT),
    .REFRESH_CYC(REFRESH_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .listo(listo), .sw(sw),
    .posicion(posicion), .enable_inicio(enable_inicio),
    .enable_escribir(enable_escribir), .enable_leer(enable_leer),
    .estado(estado), .ocupado(ocupado), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0=init 1=idle 2=write 3=read
  int m_est, m_pos, m_idle, m_wait;
  bit m_pend, m_sw_prev, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_est = 0; m_pos = 0; m_idle = 0; m_wait = 0;
    m_pend = 0; m_sw_prev = 0; m_err = 0;
  endtask

  task automatic model_step(input bit l, input bit s);
    bit rise;
    int len;
    rise      = s && !m_sw_prev;
    m_sw_prev = s;
    m_err     = 0;
    if (m_est == 1) begin
      if (rise || m_pend) begin
        m_est = 2; m_pos = 0; m_pend = 0; m_idle = 0;
      end else if (m_idle == REFRESH_CYC - 1) begin
        m_est = 3; m_pos = 0; m_idle = 0;
      end else begin
        m_idle++;
      end
    end else begin
      len = (m_est == 0) ? N_INIT : N_POS;
      if (rise) m_pend = 1;
      if (l) begin
        m_wait = 0;
        if (m_pos == len - 1) begin
          m_est = 1; m_pos = 0;
        end else begin
          m_pos++;
        end
      end else begin
`ifdef FSM_SEQ_TIMEOUT_EN
        if (m_wait == TIMEOUT_CYC - 1) begin
          m_err = 1; m_wait = 0; m_pos = 0;
          if (m_est != 0) m_est = 1;
        end else begin
          m_wait++;
        end
`endif
      end
    end
  endtask

  task automatic check_outs(input string tag);
    logic [9:0] exp_v, obs_v;
    exp_v = {3'(m_est), 2'(m_pos), (m_est == 0), (m_est == 2), (m_est == 3), (m_est != 1), m_err};
    obs_v = {estado, posicion, enable_inicio, enable_escribir, enable_leer, ocupado, error};
    check(tag, 32'(obs_v), 32'(exp_v));
    check({tag, "_onehot"}, 32'($countones({enable_inicio, enable_escribir, enable_leer}) <= 1), 32'd1);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic tick(input bit l, input bit s, input string tag);
    listo = l;
    sw    = s;
    @(posedge clk);
    model_step(l, s);
    #1;
    check_outs(tag);
    @(negedge clk);
  endtask

  task automatic hold_reset(input int n, input string tag);
    reset = 1'b0;
    listo = 1'b0;
    #1;
    model_reset();
    check_outs({tag, "_async"});
    repeat (n) begin
      @(posedge clk);
      #1;
      check_outs({tag, "_hold"});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] target, input bit l, input string tag);
    bit hit;
    hit = 0;
    for (int n = 0; n < 60; n++) begin
      if (estado == target) begin
        hit = 1;
        break;
      end
      tick(l, 1'b0, tag);
    end
    check({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  initial begin
    int lat;
    int wr_entries;
    logic [2:0] prev_est;
    bit sw_r;

    reset = 1'b0;
    listo = 1'b0;
    sw    = 1'b0;
    model_reset();
    @(negedge clk);

    // 1: reset, init burst of two steps
    hold_reset(3, "t1_reset");
    check("t1_rst_estado", 32'(estado), 32'd0);
    check("t1_rst_inicio", 32'(enable_inicio), 32'd1);
    tick(1'b1, 1'b0, "t1_step1");
    check("t1_pos1", 32'(posicion), 32'd1);
    tick(1'b1, 1'b0, "t1_step2");
    check("t1_idle", 32'(estado), 32'd1);
    check("t1_ocupado", 32'(ocupado), 32'd0);

    // 2: refresh read latency and burst
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick(1'b0, 1'b0, "t2_wait");
      if (estado == 3'd3) begin lat = n; break; end
    end
    check("t2_read_latency", 32'(lat), 32'd8);
    for (int k = 0; k < N_POS; k++) begin
      check("t2_read_pos", 32'(posicion), 32'(k));
      check("t2_leer", 32'(enable_leer), 32'd1);
      tick(1'b1, 1'b0, "t2_read");
    end
    check("t2_back_idle", 32'(estado), 32'd1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick(1'b0, 1'b0, "t2_wait2");
      if (estado == 3'd3) begin lat = n; break; end
    end
    check("t2_read_latency2", 32'(lat), 32'd8);
    repeat (N_POS) tick(1'b1, 1'b0, "t2_read2");

    // 3: sw held high gives a single write burst
    tick(1'b0, 1'b1, "t3_rise");
    check("t3_write", 32'(estado), 32'd2);
    check("t3_escribir", 32'(enable_escribir), 32'd1);
    wr_entries = 0;
    prev_est = estado;
    for (int n = 0; n < 100; n++) begin
      tick(1'($urandom_range(0, 1)), 1'b1, "t3_hold");
      if (estado == 3'd2 && prev_est != 3'd2) wr_entries++;
      prev_est = estado;
    end
    check("t3_no_rewrite", 32'(wr_entries), 32'd0);

    // 4: sw rise during read is latched and serviced after one idle cycle
    wait_state(3'd1, 1'b1, "t4_go_idle");
    wait_state(3'd3, 1'b0, "t4_go_read");
    tick(1'b1, 1'b0, "t4_r1");
    tick(1'b1, 1'b0, "t4_r2");
    check("t4_pos2", 32'(posicion), 32'd2);
    tick(1'b0, 1'b1, "t4_rise");
    tick(1'b1, 1'b1, "t4_r3");
    check("t4_pos3", 32'(posicion), 32'd3);
    tick(1'b1, 1'b1, "t4_end");
    check("t4_idle1", 32'(estado), 32'd1);
    tick(1'b0, 1'b1, "t4_pend");
    check("t4_write", 32'(estado), 32'd2);
    check("t4_write_pos", 32'(posicion), 32'd0);
    repeat (N_POS) tick(1'b1, 1'b1, "t4_wburst");
    tick(1'b0, 1'b1, "t4_nopend");
    check("t4_pend_clear", 32'(estado), 32'd1);

    // 5: reset in the middle of a write burst
    tick(1'b0, 1'b0, "t5_low");
    tick(1'b0, 1'b1, "t5_rise");
    check("t5_write", 32'(estado), 32'd2);
    tick(1'b1, 1'b1, "t5_w1");
    tick(1'b1, 1'b1, "t5_w2");
    check("t5_pos2", 32'(posicion), 32'd2);
    reset = 1'b0;
    #1;
    check("t5_estado", 32'(estado), 32'd0);
    check("t5_pos", 32'(posicion), 32'd0);
    check("t5_inicio", 32'(enable_inicio), 32'd1);
    check("t5_escribir", 32'(enable_escribir), 32'd0);
    @(negedge clk);
    hold_reset(1, "t5_reset");
    tick(1'b1, 1'b0, "t5_init1");
    tick(1'b1, 1'b0, "t5_init2");

`ifdef FSM_SEQ_TIMEOUT_EN
    // 6: watchdog expiry versus listo in the expiry cycle
    wait_state(3'd3, 1'b0, "t6_go_read");
    repeat (TIMEOUT_CYC - 1) tick(1'b0, 1'b0, "t6_starve");
    check("t6_pre_err", 32'(error), 32'd0);
    tick(1'b0, 1'b0, "t6_expire");
    check("t6_err", 32'(error), 32'd1);
    check("t6_err_idle", 32'(estado), 32'd1);
    tick(1'b0, 1'b0, "t6_after");
    check("t6_err_pulse", 32'(error), 32'd0);
    wait_state(3'd3, 1'b0, "t6_go_read2");
    repeat (TIMEOUT_CYC - 1) tick(1'b0, 1'b0, "t6_starve2");
    tick(1'b1, 1'b0, "t6_save");
    check("t6_saved_err", 32'(error), 32'd0);
    check("t6_saved_pos", 32'(posicion), 32'd1);
`endif

    // Randomized traffic with occasional resets
    sw_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) sw_r = ~sw_r;
      if ($urandom_range(0, 299) == 0) begin
        sw = sw_r;
        hold_reset(1 + $urandom_range(0, 2), "rnd_reset");
      end else begin
        tick(1'($urandom_range(0, 3) != 0), sw_r, "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
